mode_decoder: RTL

MODE_DECODER -- requirements
Module: mode_decoder

---
 rtl/mode_decoder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mode_decoder.sv
// mode_decoder: measures the mode_clock period in SCLK cycles and locks SW onto DIV1..DIV3 after two matching periods.
// Optional LD period output is built only when MODE_DECODER_LD_EN is defined.
module mode_decoder #(
  parameter int DIV1    = 1000,
  parameter int DIV2    = 500,
  parameter int DIV3    = 200,
  parameter int TOL     = 4,
  parameter int TIMEOUT = 4000
) (
  input  logic        SCLK,
  input  logic        RST_N,
  input  logic        mode_clock,
  output logic [1:0]  SW,
  output logic        valid,
  output logic        mode_change,
  output logic [15:0] LD
);

  typedef enum logic [1:0] {IDLE, ARMED, TRACK, LOCK} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  sync_q;
  logic        strobe;
  logic        timeout_hit;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  cand_q, cand_d;
  logic [1:0]  sw_q, sw_d;
  logic        valid_q, valid_d;
  logic        mc_q;
  logic [1:0]  cls;

  function automatic logic in_tol(input logic [15:0] p, input int div);
    int diff;
    diff = $signed({16'd0, p}) - div;
    return (diff >= -TOL) && (diff <= TOL);
  endfunction

  // Lowest class index wins when tolerance windows overlap.
  function automatic logic [1:0] classify(input logic [15:0] p);
    if (in_tol(p, DIV1))      return 2'd1;
    else if (in_tol(p, DIV2)) return 2'd2;
    else if (in_tol(p, DIV3)) return 2'd3;
    else                      return 2'd0;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Synchronizer stage: edge is seen on the third flop against the second.
  always_ff @(posedge SCLK) begin
    if (!RST_N) sync_q <= 3'b000;
    else        sync_q <= {sync_q[1:0], mode_clock};
  end

  assign strobe      = sync_q[1] & ~sync_q[2];
  assign timeout_hit = (state_q != IDLE) && (cnt_q == TO_LAST);
  assign cls         = classify(cnt_q);

  always_comb begin
    cnt_d = cnt_q;
    if (strobe)                cnt_d = 16'd1;
    else if (state_q != IDLE)  cnt_d = sat_inc(cnt_q);
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    sw_d    = sw_q;
    valid_d = valid_q;
    if (strobe) begin
      case (state_q)
        IDLE:  state_d = ARMED;
        ARMED: begin
          if (cls != 2'd0) begin
            state_d = TRACK;
            cand_d  = cls;
          end
        end
        TRACK: begin
          if (cls == 2'd0) begin
            state_d = ARMED;
          end else if (cls == cand_q) begin
            state_d = LOCK;
            sw_d    = cls;
            valid_d = 1'b1;
          end else begin
            cand_d  = cls;
          end
        end
        LOCK: begin
          if (cls != sw_q) begin
            sw_d    = 2'd0;
            valid_d = 1'b0;
            if (cls == 2'd0) begin
              state_d = ARMED;
            end else begin
              state_d = TRACK;
              cand_d  = cls;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout_hit) begin
      state_d = IDLE;
      sw_d    = 2'd0;
      valid_d = 1'b0;
    end
  end

  // Control/state register stage.
  always_ff @(posedge SCLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      cand_q  <= 2'd0;
      sw_q    <= 2'd0;
      valid_q <= 1'b0;
      mc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      sw_q    <= sw_d;
      valid_q <= valid_d;
      mc_q    <= (sw_d != sw_q);
    end
  end

  assign SW          = sw_q;
  assign valid       = valid_q;
  assign mode_change = mc_q;

`ifdef MODE_DECODER_LD_EN
  logic [15:0] ld_q;

  always_ff @(posedge SCLK) begin
    if (!RST_N)                        ld_q <= 16'd0;
    else if (strobe && state_q != IDLE) ld_q <= cnt_q;
  end

  assign LD = ld_q;
`else
  assign LD = 16'h0000;
`endif

endmodule
